// File: rtl/shift16_pkg.sv
// shift16_pkg: shared constants for the shift16 deserializer slice
package shift16_pkg;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;
  localparam int PTR_W = 1;
endpackage

// File: rtl/word_fifo2.sv
// word_fifo2: 2-entry register FIFO; a push on full is taken when a pop frees the head the same cycle
module word_fifo2 import shift16_pkg::*; #(
  parameter int W = WIDTH,
  parameter int D = DEPTH
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);
  logic [W-1:0] mem [2];
  logic [PTR_W-1:0] rd;
  logic [PTR_W:0] cnt;
  logic do_push, do_pop;
  assign valid = cnt != '0;
  assign full = cnt == (PTR_W+1)'(D);
  assign do_pop = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign head = valid ? mem[rd] : '0;
  // tail slot is rd^cnt[0]; when full this is the head slot being popped
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      mem <= '{default: '0};
      rd <= '0;
      cnt <= '0;
    end else if (Clear) begin
      mem <= '{default: '0};
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) mem[rd ^ cnt[0]] <= push_data;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/shift16_deser.sv
// shift16_deser: MSB-first serial-to-parallel receiver with framing, 2-word buffer and sticky status
module shift16_deser import shift16_pkg::CNT_W; #(
  parameter int WIDTH = shift16_pkg::WIDTH,
  parameter int DEPTH = shift16_pkg::DEPTH
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Clear,
  input  logic             SerIn,
  input  logic             SerValid,
  input  logic             Sync,
  output logic [WIDTH-1:0] Word,
  output logic             WordValid,
  input  logic             WordReady,
  output logic [CNT_W-1:0] BitCount,
  output logic             Overrun,
  output logic             FrameErr
);
  logic [WIDTH-1:0] sreg, next_word;
  logic [CNT_W-1:0] base;
  logic last, pop, full;
  assign base = Sync ? '0 : BitCount;
  assign last = SerValid & (base == CNT_W'(WIDTH - 1));
  assign next_word = {sreg[WIDTH-2:0], SerIn};
  assign pop = WordValid & WordReady;
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      sreg <= '0;
      BitCount <= '0;
      Overrun <= 1'b0;
      FrameErr <= 1'b0;
    end else if (Clear) begin
      sreg <= '0;
      BitCount <= '0;
      Overrun <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      if (SerValid) begin
        sreg <= next_word;
        BitCount <= last ? '0 : base + CNT_W'(1);
      end else if (Sync) BitCount <= '0;
      if (Sync && BitCount != '0) FrameErr <= 1'b1;
      if (last && full && !pop) Overrun <= 1'b1;
    end
  word_fifo2 #(.W(WIDTH), .D(DEPTH)) u_fifo (
    .Clock(Clock),
    .nReset(nReset),
    .Clear(Clear),
    .push(last),
    .push_data(next_word),
    .pop(pop),
    .head(Word),
    .valid(WordValid),
    .full(full)
  );
endmodule

// File: tb/tb_shift16_deser.sv
// tb_shift16_deser: directed table, hand-written corner sequences and random traffic against a queue model
module tb_shift16_deser;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, clear = 0, ser_in = 0, ser_valid = 0, sync = 0, word_ready = 0;
  logic [W-1:0] word;
  logic word_valid, overrun, frame_err;
  logic [4:0] bit_count;
  int nvec = 0, nerr = 0;
  int m_cnt;
  logic [W-1:0] m_part;
  logic [W-1:0] m_q[$];
  bit m_ovr, m_fe;

  typedef struct {
    logic [W-1:0] w;
    bit gap;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  shift16_deser dut (
    .Clock(clk), .nReset(rst_n), .Clear(clear), .SerIn(ser_in), .SerValid(ser_valid),
    .Sync(sync), .Word(word), .WordValid(word_valid), .WordReady(word_ready),
    .BitCount(bit_count), .Overrun(overrun), .FrameErr(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0;
    m_part = '0;
    m_q.delete();
    m_ovr = 0;
    m_fe = 0;
  endtask

  task automatic m_update(input bit c, input bit sv, input bit si, input bit sy, input bit rdy);
    int n;
    bit done, do_pop;
    logic [W-1:0] done_word;
    if (c) begin
      m_reset();
      return;
    end
    done = 0;
    do_pop = rdy && m_q.size() > 0;
    n = sy ? 0 : m_cnt;
    if (sy && m_cnt != 0) m_fe = 1;
    if (sv) begin
      m_part = {m_part[W-2:0], si};
      n++;
      if (n == W) begin
        done = 1;
        done_word = m_part;
        n = 0;
      end
    end
    m_cnt = n;
    if (do_pop) void'(m_q.pop_front());
    if (done) begin
      if (m_q.size() < 2) m_q.push_back(done_word);
      else m_ovr = 1;
    end
  endtask

  task automatic check_model();
    chk("valid", {31'b0, word_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("word", {16'b0, word}, {16'b0, m_q[0]});
    chk("bitcount", {27'b0, bit_count}, m_cnt);
    chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    chk("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
  endtask

  task automatic step(input bit c, input bit sv, input bit si, input bit sy, input bit rdy);
    clear = c;
    ser_valid = sv;
    ser_in = si;
    sync = sy;
    word_ready = rdy;
    @(posedge clk);
    m_update(c, sv, si, sy, rdy);
    #1 check_model();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit sy, input bit gap, input bit rdy);
    for (int i = W - 1; i >= W - nbits; i--) begin
      step(0, 1, w[i], sy && i == W - 1, rdy);
      if (gap && i > W - nbits) step(0, 0, 0, 0, rdy);
    end
  endtask

  task automatic do_clear();
    step(1, 0, 0, 0, 0);
    chk("clear_valid", {31'b0, word_valid}, 0);
    chk("clear_ovr", {31'b0, overrun}, 0);
    chk("clear_fe", {31'b0, frame_err}, 0);
  endtask

  initial begin
    tbl[0] = '{16'hA5C3, 0, 16'hA5C3};
    tbl[1] = '{16'hA5C3, 1, 16'hA5C3};
    tbl[2] = '{16'h8001, 0, 16'h8001};
    tbl[3] = '{16'h0F0F, 1, 16'h0F0F};
    m_reset();
    #1;
    chk("rst_word", {16'b0, word}, 0);
    chk("rst_valid", {31'b0, word_valid}, 0);
    chk("rst_cnt", {27'b0, bit_count}, 0);
    chk("rst_flags", {30'b0, overrun, frame_err}, 0);
    @(negedge clk) rst_n = 1;

    // single words, back-to-back and gapped, one-cycle output with ready held
    foreach (tbl[k]) begin
      send_bits(tbl[k].w, W, 1, tbl[k].gap, 1);
      chk("tbl_word", {16'b0, word}, {16'b0, tbl[k].exp});
      chk("tbl_valid", {31'b0, word_valid}, 1);
      chk("tbl_cnt", {27'b0, bit_count}, 0);
      chk("tbl_flags", {30'b0, overrun, frame_err}, 0);
      step(0, 0, 0, 0, 1);
      chk("tbl_valid_gone", {31'b0, word_valid}, 0);
    end

    // overrun: third word dropped while consumer stalls
    send_bits(16'h1111, W, 1, 0, 0);
    send_bits(16'h2222, W, 1, 0, 0);
    send_bits(16'h3333, W, 1, 0, 0);
    chk("ovr_word", {16'b0, word}, 16'h1111);
    chk("ovr_flag", {31'b0, overrun}, 1);
    step(0, 0, 0, 0, 1);
    chk("ovr_second", {16'b0, word}, 16'h2222);
    step(0, 0, 0, 0, 1);
    chk("ovr_empty", {31'b0, word_valid}, 0);
    send_bits(16'h4444, W, 1, 0, 0);
    chk("ovr_sticky", {31'b0, overrun}, 1);
    do_clear();

    // full buffer, last bit lands in the same cycle as a pop
    send_bits(16'h1111, W, 1, 0, 0);
    send_bits(16'h2222, W, 1, 0, 0);
    send_bits(16'hBEEF, W - 1, 1, 0, 0);
    step(0, 1, 1'b1, 0, 1);
    chk("fp_ovr", {31'b0, overrun}, 0);
    chk("fp_head", {16'b0, word}, 16'h2222);
    step(0, 0, 0, 0, 1);
    chk("fp_beef", {16'b0, word}, 16'hBEEF);
    step(0, 0, 0, 0, 1);
    chk("fp_empty", {31'b0, word_valid}, 0);

    // frame error: partial word of five ones discarded by a new sync
    send_bits(16'hFFFF, 5, 1, 0, 1);
    chk("fe_partial", {27'b0, bit_count}, 5);
    send_bits(16'h0F0F, W, 1, 0, 1);
    chk("fe_flag", {31'b0, frame_err}, 1);
    chk("fe_word", {16'b0, word}, 16'h0F0F);
    step(0, 0, 0, 0, 1);
    chk("fe_single", {31'b0, word_valid}, 0);
    do_clear();

    // async reset mid-word
    send_bits(16'hFFFF, 7, 1, 0, 1);
    chk("mid_cnt", {27'b0, bit_count}, 7);
    #2 rst_n = 0;
    #1;
    chk("arst_cnt", {27'b0, bit_count}, 0);
    chk("arst_out", {15'b0, word, word_valid}, 0);
    m_reset();
    @(negedge clk) rst_n = 1;
    send_bits(16'h8001, W, 0, 0, 1);
    chk("arst_word", {16'b0, word}, 16'h8001);
    step(0, 0, 0, 0, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/shift16_deser.md
Name: shift16_deser

Overview:
- Serial-to-parallel receive stage directly downstream of the 16-bit left-shifting LPM shift register; it consumes that register's ShiftOut stream, MSB first.
- Reassembles WIDTH-bit words, buffers up to 2 of them, and hands them on through a valid/ready interface.
- Flags framing errors and overruns as sticky status bits.
- Sits between the serializer datapath and the parallel consumer (bus interface or capture logic).

Parameters:
- WIDTH, 16, word width and bits per frame (≥2).
- DEPTH, 2, output buffer entries (fixed at 2; parameter exists for package consistency only).

Ports:
- Clock  in  1  single system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous clear of counter, buffer and sticky flags.
- SerIn  in  1  serial data bit (ShiftOut of upstream register).
- SerValid  in  1  SerIn is valid this cycle (same strobe as upstream Enable with Load=0).
- Sync  in  1  frame start; the bit qualified in this cycle, if any, is bit WIDTH-1 of a new word.
- Word  out  WIDTH  head-of-buffer word.
- WordValid  out  1  Word holds a valid entry.
- WordReady  in  1  consumer accepts Word.
- BitCount  out  5  bits received in the current partial word (0..WIDTH-1).
- Overrun  out  1  sticky: a completed word was dropped.
- FrameErr  out  1  sticky: Sync arrived with a partial word pending.

Behaviour:
- Reset (nReset=0, asynchronous): shift register, BitCount, buffer pointers/count, Overrun and FrameErr all 0. WordValid=0. Word=0.
- Clear=1 (synchronous): same effect as reset. Highest priority; SerValid, Sync and pop are ignored in that cycle.
- Bit accept on SerValid=1: sreg <= {sreg[WIDTH-2:0], SerIn}; BitCount increments.
- Word completion: SerValid=1 with BitCount=WIDTH-1 makes the word {sreg[WIDTH-2:0], SerIn}. It is pushed to the buffer and BitCount wraps to 0.
- Sync=1:
  - Effective BitCount is forced to 0 before the bit is accepted.
  - If BitCount≠0 at that moment, the partial word is discarded and FrameErr is set.
  - Sync with SerValid=1 accepts SerIn as the first bit, so BitCount becomes 1.
  - Sync with SerValid=0 only sets BitCount to 0.
- Latency: the word appears on Word/WordValid in the cycle after the edge that samples its last bit (1 clock). There is no combinational path from SerIn to Word.
- Gaps in SerValid are allowed at any point. The counter holds while SerValid=0.
- Buffer:
  - 2-entry FIFO, first in first out.
  - WordValid = (count≠0); Word = head entry.
  - Pop occurs when WordValid & WordReady.
  - Word and WordValid must stay stable while WordValid=1 and WordReady=0.
- Simultaneous push and pop: always legal, including when the buffer is full. The count is unchanged and order is preserved.
- Push when full without pop: the new word is dropped, the buffer is untouched, and Overrun is set.
- Pop when empty: ignored.
- Sticky flags clear only on nReset or Clear.
- Reset mid-word: the partial word is lost. After deassertion the first qualified bit is bit WIDTH-1 of a new word.
- Width rule: BitCount is 5 bits wide, with the upper bits zero for WIDTH<16. WIDTH>32 is not supported.

Decomposition:
- Package shift16_pkg holds:
  - constants WIDTH=16, DEPTH=2, CNT_W=5;
  - pointer width PTR_W=1.
- One sub-module, word_fifo2: 2-entry register FIFO.
  - Ports: Clock, nReset, Clear, push, push_data, pop, head, valid, full.
  - Push-on-full-with-pop is accepted.
  - Instantiated once.
- The top level keeps the shift register, bit counter, framing logic and sticky flags.

Test Plan:
- Serial word: Sync on first bit, shift 0xA5C3 MSB first with SerValid=1 for 16 cycles, WordReady=1 → Word=0xA5C3, WordValid=1 for exactly 1 cycle, starting the cycle after the 16th bit. BitCount=0. No flags set.
- Gapped input: same word with SerValid toggling 1,0,1,0… → Word=0xA5C3 one cycle after the last qualified bit. BitCount holds during gaps.
- Overrun: words 0x1111, 0x2222, 0x3333 back to back with WordReady=0 → WordValid=1, Word=0x1111. Overrun=1 after the 3rd word. Raising WordReady then yields 0x1111, then 0x2222, then WordValid=0; 0x3333 is never output.
- Full push with pop: buffer holds 0x1111 and 0x2222; the 16th bit of 0xBEEF completes in the same cycle as a pop → Overrun stays 0. Output sequence is 0x2222, then 0xBEEF.
- Frame error: 5 bits of 1s, then Sync with SerValid=1 and 16 bits of 0x0F0F → FrameErr=1, single output word 0x0F0F.
- Reset/clear: nReset pulsed low mid-word (BitCount=7) → all outputs 0 immediately. Next 16 bits of 0x8001 give Word=0x8001. Clear=1 for one cycle while Overrun=1 → Overrun=0 and WordValid=0 the next cycle.
